// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the multi-thread PC sequencer
package pc_seq_pkg;

    localparam int INST_ADDR_WIDTH_DEF = 6;
    localparam int NUM_THREADS_DEF     = 4;
    localparam int TID_WIDTH_DEF       = 2;
    localparam int RAS_DEPTH_DEF       = 4;

    // Word address to byte address: instructions are 4-byte aligned
    localparam int PC_BYTE_SHIFT = 2;

    typedef enum logic {
        HALTED  = 1'b0,
        RUNNING = 1'b1
    } thread_state_t;

    typedef logic [TID_WIDTH_DEF-1:0]       tid_t;
    typedef logic [INST_ADDR_WIDTH_DEF-1:0] word_addr_t;

endpackage

// File: rtl/pc_rr_picker.sv
// rtl/pc_rr_picker.sv - round-robin selection of the first running thread at or after a pointer
module pc_rr_picker #(
    parameter int NUM_THREADS = 4,
    parameter int TID_WIDTH   = 2
) (
    input  logic [NUM_THREADS-1:0] running_mask_i,
    input  logic [TID_WIDTH-1:0]   rr_ptr_i,
    output logic [TID_WIDTH-1:0]   sel_tid_o,
    output logic                   any_running_o
);

    logic [2*NUM_THREADS-1:0] doubled;

    // Rotate the mask so bit 0 is the pointer position; thread count is a power of 2 so tid addition wraps
    always_comb begin
        doubled       = {running_mask_i, running_mask_i} >> rr_ptr_i;
        sel_tid_o     = rr_ptr_i;
        any_running_o = 1'b0;
        for (int k = NUM_THREADS - 1; k >= 0; k--) begin
            if (doubled[k]) begin
                any_running_o = 1'b1;
                sel_tid_o     = rr_ptr_i + TID_WIDTH'(k);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer_mt.sv
// rtl/pc_sequencer_mt.sv - per-thread PCs with round-robin fetch issue; return stack under PC_SEQ_RAS_EN
module pc_sequencer_mt
    import pc_seq_pkg::*;
#(
    parameter int INST_ADDR_WIDTH = INST_ADDR_WIDTH_DEF,
    parameter int NUM_THREADS     = NUM_THREADS_DEF,
    parameter int TID_WIDTH       = TID_WIDTH_DEF,
    parameter int RESET_VECTOR    = 0,
    parameter int RAS_DEPTH       = RAS_DEPTH_DEF
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     en,
    input  logic                                     stall,
    input  logic                                     redirect_en,
    input  logic [TID_WIDTH-1:0]                     redirect_tid,
    input  logic [INST_ADDR_WIDTH-1:0]               redirect_addr,
    input  logic                                     start_en,
    input  logic                                     halt_en,
`ifdef PC_SEQ_RAS_EN
    input  logic                                     call_en,
    input  logic                                     ret_en,
    output logic                                     ras_underflow,
`endif
    output logic [INST_ADDR_WIDTH+PC_BYTE_SHIFT-1:0] pc_out,
    output logic [TID_WIDTH-1:0]                     pc_tid,
    output logic                                     pc_valid,
    output logic [NUM_THREADS-1:0]                   thread_running
);

    localparam int AW = INST_ADDR_WIDTH;
    localparam int OW = INST_ADDR_WIDTH + PC_BYTE_SHIFT;

    thread_state_t          state_q [NUM_THREADS];
    thread_state_t          state_d [NUM_THREADS];
    logic [AW-1:0]          pc_q    [NUM_THREADS];
    logic [AW-1:0]          pc_d    [NUM_THREADS];
    logic [TID_WIDTH-1:0]   rr_q, rr_d;
    logic [OW-1:0]          pc_out_q, pc_out_d;
    logic [TID_WIDTH-1:0]   pc_tid_q, pc_tid_d;
    logic                   pc_valid_q, pc_valid_d;

    logic [NUM_THREADS-1:0] running_mask;
    logic [TID_WIDTH-1:0]   sel_tid;
    logic                   any_running;
    logic                   issue;
    logic                   start_eff;
    logic                   do_load;

    // A halt and start on the same thread cancel the start entirely, including its PC load
    assign issue     = en & ~stall & any_running;
    assign start_eff = start_en & ~halt_en;
    assign do_load   = en & (redirect_en | start_eff);

    // Running mask from the registered thread states; a thread started this cycle is not yet visible
    always_comb begin
        running_mask = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            running_mask[t] = (state_q[t] == RUNNING);
        end
    end

    pc_rr_picker #(
        .NUM_THREADS (NUM_THREADS),
        .TID_WIDTH   (TID_WIDTH)
    ) u_picker (
        .running_mask_i (running_mask),
        .rr_ptr_i       (rr_q),
        .sel_tid_o      (sel_tid),
        .any_running_o  (any_running)
    );

`ifdef PC_SEQ_RAS_EN
    localparam int RPW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int RCW = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0]  ras_q      [NUM_THREADS][RAS_DEPTH];
    logic [AW-1:0]  ras_d      [NUM_THREADS][RAS_DEPTH];
    logic [RPW-1:0] ras_wp_q   [NUM_THREADS];
    logic [RPW-1:0] ras_wp_d   [NUM_THREADS];
    logic [RCW-1:0] ras_cnt_q  [NUM_THREADS];
    logic [RCW-1:0] ras_cnt_d  [NUM_THREADS];
    logic           ras_uf_q, ras_uf_d;
    logic [RPW-1:0] wp_cur, wp_prev;
    logic [AW-1:0]  ras_top;
    logic           ras_empty;
    logic           do_call, do_ret;

    assign do_call   = en & ~do_load & call_en;
    assign do_ret    = en & ~do_load & ~call_en & ret_en;
    assign wp_cur    = ras_wp_q[redirect_tid];
    assign wp_prev   = (wp_cur == '0) ? RPW'(RAS_DEPTH - 1) : wp_cur - 1'b1;
    assign ras_top   = ras_q[redirect_tid][wp_prev];
    assign ras_empty = (ras_cnt_q[redirect_tid] == '0);

    // Circular return stack: a push when full overwrites the oldest entry, a pop when empty flags underflow
    always_comb begin
        ras_d     = ras_q;
        ras_wp_d  = ras_wp_q;
        ras_cnt_d = ras_cnt_q;
        ras_uf_d  = 1'b0;
        if (do_call) begin
            ras_d[redirect_tid][wp_cur] = pc_q[redirect_tid] + 1'b1;
            ras_wp_d[redirect_tid]      = (wp_cur == RPW'(RAS_DEPTH - 1)) ? '0 : wp_cur + 1'b1;
            if (ras_cnt_q[redirect_tid] != RCW'(RAS_DEPTH)) begin
                ras_cnt_d[redirect_tid] = ras_cnt_q[redirect_tid] + 1'b1;
            end
        end else if (do_ret) begin
            if (ras_empty) begin
                ras_uf_d = 1'b1;
            end else begin
                ras_wp_d[redirect_tid]  = wp_prev;
                ras_cnt_d[redirect_tid] = ras_cnt_q[redirect_tid] - 1'b1;
            end
        end
    end

    // Return stack registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int d = 0; d < RAS_DEPTH; d++) begin
                    ras_q[t][d] <= '0;
                end
                ras_wp_q[t]  <= '0;
                ras_cnt_q[t] <= '0;
            end
            ras_uf_q <= 1'b0;
        end else begin
            ras_q     <= ras_d;
            ras_wp_q  <= ras_wp_d;
            ras_cnt_q <= ras_cnt_d;
            ras_uf_q  <= ras_uf_d;
        end
    end

    assign ras_underflow = ras_uf_q;
`endif

    // Per-thread state FSM: halt beats start when both target the same thread
    always_comb begin
        state_d = state_q;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (en && (redirect_tid == TID_WIDTH'(t))) begin
                if (halt_en) begin
                    state_d[t] = HALTED;
                end else if (start_en) begin
                    state_d[t] = RUNNING;
                end
            end
        end
    end

    // Issue and PC update; a load on the target thread overrides its increment, the old PC is still issued
    always_comb begin
        pc_d       = pc_q;
        rr_d       = rr_q;
        pc_out_d   = pc_out_q;
        pc_tid_d   = pc_tid_q;
        pc_valid_d = 1'b0;
        if (issue) begin
            pc_out_d      = {pc_q[sel_tid], {PC_BYTE_SHIFT{1'b0}}};
            pc_tid_d      = sel_tid;
            pc_valid_d    = 1'b1;
            pc_d[sel_tid] = pc_q[sel_tid] + 1'b1;
            rr_d          = (NUM_THREADS == 1) ? '0 : sel_tid + 1'b1;
        end
        if (do_load) begin
            pc_d[redirect_tid] = redirect_addr;
        end
`ifdef PC_SEQ_RAS_EN
        else if (do_call) begin
            pc_d[redirect_tid] = redirect_addr;
        end else if (do_ret) begin
            pc_d[redirect_tid] = ras_empty ? '0 : ras_top;
        end
`endif
    end

    // State, PC and output registers; thread 0 comes out of reset running at the reset vector
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= (t == 0) ? RUNNING : HALTED;
                pc_q[t]    <= (t == 0) ? AW'(RESET_VECTOR) : '0;
            end
            rr_q       <= '0;
            pc_out_q   <= '0;
            pc_tid_q   <= '0;
            pc_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rr_q       <= rr_d;
            pc_out_q   <= pc_out_d;
            pc_tid_q   <= pc_tid_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    assign pc_out         = pc_out_q;
    assign pc_tid         = pc_tid_q;
    assign pc_valid       = pc_valid_q;
    assign thread_running = running_mask;

endmodule

// File: tb/tb_pc_sequencer_mt.sv
// tb/tb_pc_sequencer_mt.sv - self-checking bench for pc_sequencer_mt against a behavioural model
module tb_pc_sequencer_mt;
    import pc_seq_pkg::*;

    localparam int NT    = 4;
    localparam int AW    = 6;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       stall;
    logic       redirect_en;
    logic [1:0] redirect_tid;
    logic [5:0] redirect_addr;
    logic       start_en;
    logic       halt_en;
    logic [7:0] pc_out;
    logic [1:0] pc_tid;
    logic       pc_valid;
    logic [3:0] thread_running;
`ifdef PC_SEQ_RAS_EN
    logic       call_en;
    logic       ret_en;
    logic       ras_underflow;
`endif

    always #5 clk = ~clk;

    pc_sequencer_mt #(
        .INST_ADDR_WIDTH (AW),
        .NUM_THREADS     (NT),
        .TID_WIDTH       (2),
        .RESET_VECTOR    (0),
        .RAS_DEPTH       (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .stall          (stall),
        .redirect_en    (redirect_en),
        .redirect_tid   (redirect_tid),
        .redirect_addr  (redirect_addr),
        .start_en       (start_en),
        .halt_en        (halt_en),
`ifdef PC_SEQ_RAS_EN
        .call_en        (call_en),
        .ret_en         (ret_en),
        .ras_underflow  (ras_underflow),
`endif
        .pc_out         (pc_out),
        .pc_tid         (pc_tid),
        .pc_valid       (pc_valid),
        .thread_running (thread_running)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: thread PCs as plain integers, return stacks as queues
    int m_pc [NT];
    bit m_run [NT];
    int m_rr;
    int m_out;
    int m_tid;
    bit m_valid;
    bit m_uf;
    int m_ras [NT][$];

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_pc[t]  = 0;
            m_run[t] = (t == 0);
            m_ras[t].delete();
        end
        m_rr = 0; m_out = 0; m_tid = 0; m_valid = 0; m_uf = 0;
    endtask

    task automatic model_step(input bit e, input bit s, input bit rd, input int tid, input int addr,
                              input bit st, input bit hl, input bit cl, input bit rt);
        int old_pc;
        int sel;
        old_pc  = m_pc[tid];
        m_valid = 0;
        m_uf    = 0;
        if (e) begin
            sel = -1;
            for (int k = 0; k < NT; k++) begin
                if (sel < 0 && m_run[(m_rr + k) % NT]) sel = (m_rr + k) % NT;
            end
            if (!s && sel >= 0) begin
                m_valid   = 1;
                m_out     = m_pc[sel] * 4;
                m_tid     = sel;
                m_pc[sel] = (m_pc[sel] + 1) % (1 << AW);
                m_rr      = (sel + 1) % NT;
            end
            if (rd || (st && !hl)) begin
                m_pc[tid] = addr;
            end else if (cl) begin
                if (m_ras[tid].size() == DEPTH) void'(m_ras[tid].pop_front());
                m_ras[tid].push_back((old_pc + 1) % (1 << AW));
                m_pc[tid] = addr;
            end else if (rt) begin
                if (m_ras[tid].size() == 0) begin
                    m_pc[tid] = 0;
                    m_uf      = 1;
                end else begin
                    m_pc[tid] = m_ras[tid].pop_back();
                end
            end
            if (hl) m_run[tid] = 0;
            else if (st) m_run[tid] = 1;
        end
    endtask

    task automatic check_all();
        logic [31:0] rv;
        rv = '0;
        for (int t = 0; t < NT; t++) rv[t] = m_run[t];
        check_eq("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
        check_eq("pc_out", {24'd0, pc_out}, m_out);
        check_eq("pc_tid", {30'd0, pc_tid}, m_tid);
        check_eq("thread_running", {28'd0, thread_running}, rv);
`ifdef PC_SEQ_RAS_EN
        check_eq("ras_underflow", {31'd0, ras_underflow}, {31'd0, m_uf});
`endif
    endtask

    task automatic step(input bit e, input bit s, input bit rd, input int tid, input int addr,
                        input bit st, input bit hl, input bit cl, input bit rt);
        en            = e;
        stall         = s;
        redirect_en   = rd;
        redirect_tid  = tid[1:0];
        redirect_addr = addr[5:0];
        start_en      = st;
        halt_en       = hl;
`ifdef PC_SEQ_RAS_EN
        call_en       = cl;
        ret_en        = rt;
`endif
        model_step(e, s, rd, tid, addr, st, hl, cl, rt);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_all();
    endtask

    // Directed step with hand-derived expectations in addition to the model check
    task automatic tp(input string tag, input bit e, input bit s, input bit rd, input int tid, input int addr,
                      input bit st, input bit hl, input bit ev, input int eo, input int et);
        step(e, s, rd, tid, addr, st, hl, 1'b0, 1'b0);
        check_eq({tag, "_valid"}, {31'd0, pc_valid}, {31'd0, ev});
        check_eq({tag, "_out"}, {24'd0, pc_out}, eo);
        check_eq({tag, "_tid"}, {30'd0, pc_tid}, et);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_tid = '0;
        redirect_addr = '0; start_en = 1'b0; halt_en = 1'b0;
`ifdef PC_SEQ_RAS_EN
        call_en = 1'b0; ret_en = 1'b0;
`endif
        @(posedge clk);
        #1;
        do_reset();
        check_eq("reset_running", {28'd0, thread_running}, 32'h1);

        tp("c1", 1, 0, 0, 0, 0, 0, 0, 1, 8'h00, 0);
        tp("c2", 1, 0, 0, 0, 0, 0, 0, 1, 8'h04, 0);
        tp("c3", 1, 0, 0, 0, 0, 0, 0, 1, 8'h08, 0);
        tp("start1", 1, 0, 0, 1, 6'h10, 1, 0, 1, 8'h0C, 0);
        tp("start2", 1, 0, 0, 2, 6'h20, 1, 0, 1, 8'h40, 1);
        tp("rr_t2", 1, 0, 0, 0, 0, 0, 0, 1, 8'h80, 2);
        tp("rr_t0", 1, 0, 0, 0, 0, 0, 0, 1, 8'h10, 0);
        tp("rr_t1", 1, 0, 0, 0, 0, 0, 0, 1, 8'h44, 1);
        tp("rr_t2b", 1, 0, 0, 0, 0, 0, 0, 1, 8'h84, 2);
        tp("redir_same", 1, 0, 1, 0, 6'h03, 0, 0, 1, 8'h14, 0);
        tp("c11", 1, 0, 0, 0, 0, 0, 0, 1, 8'h48, 1);
        tp("c12", 1, 0, 0, 0, 0, 0, 0, 1, 8'h88, 2);
        tp("redir_new", 1, 0, 0, 0, 0, 0, 0, 1, 8'h0C, 0);
        tp("redir_3f", 1, 0, 1, 1, 6'h3F, 0, 0, 1, 8'h4C, 1);
        tp("c15", 1, 0, 0, 0, 0, 0, 0, 1, 8'h8C, 2);
        tp("c16", 1, 0, 0, 0, 0, 0, 0, 1, 8'h10, 0);
        tp("pc_max", 1, 0, 0, 0, 0, 0, 0, 1, 8'hFC, 1);
        tp("c18", 1, 0, 0, 0, 0, 0, 0, 1, 8'h90, 2);
        tp("c19", 1, 0, 0, 0, 0, 0, 0, 1, 8'h14, 0);
        tp("pc_wrap", 1, 0, 0, 0, 0, 0, 0, 1, 8'h00, 1);
        tp("halt_start", 1, 1, 0, 1, 6'h2A, 1, 1, 0, 8'h00, 1);
        check_eq("halt_wins", {28'd0, thread_running}, 32'h5);
        tp("stall2", 1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1);
        tp("stall3", 1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1);
        tp("post_stall_t2", 1, 0, 0, 0, 0, 0, 0, 1, 8'h94, 2);
        tp("post_stall_t0", 1, 0, 0, 0, 0, 0, 0, 1, 8'h18, 0);
        tp("skip_halted", 1, 0, 0, 0, 0, 0, 0, 1, 8'h98, 2);
        tp("en_low", 0, 0, 1, 0, 6'h3A, 0, 1, 0, 8'h98, 2);
        check_eq("en_low_running", {28'd0, thread_running}, 32'h5);
        tp("after_en_low", 1, 0, 0, 0, 0, 0, 0, 1, 8'h1C, 0);

        for (int i = 0; i < 400; i++) begin
            bit cl, rt;
            cl = 1'b0;
            rt = 1'b0;
`ifdef PC_SEQ_RAS_EN
            cl = ($urandom_range(0, 99) < 10);
            rt = ($urandom_range(0, 99) < 10);
`endif
            if (i == 200) begin
                en = 1'b1; redirect_en = 1'b1; start_en = 1'b1; redirect_tid = 2'd3;
                redirect_addr = 6'h15;
                do_reset();
            end
            step($urandom_range(0, 99) < 90, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                 $urandom_range(0, NT - 1), $urandom_range(0, 63), $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 8, cl, rt);
        end

`ifdef PC_SEQ_RAS_EN
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 6'h30, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("call_target", {24'd0, pc_out}, 32'hC0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("ret_target", {24'd0, pc_out}, 32'h0C);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        check_eq("uf_pulse", {31'd0, ras_underflow}, 32'h1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check_eq("uf_clear", {31'd0, ras_underflow}, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("uf_pc_zero", {24'd0, pc_out}, 32'h00);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer_mt.md
Name: pc_sequencer_mt

Overview:
- Multi-thread successor to the single-context PC counter in the fetch stage.
- Holds one program counter per hardware thread and round-robin issues one fetch address per enabled cycle to instruction memory.
- Supports branch redirect, thread start/halt, and word-aligned byte-address output.
- Sits between the core control unit and the instruction memory address port.

Parameters:
- INST_ADDR_WIDTH, 6, word-address width; pc_out is byte address, INST_ADDR_WIDTH+2 bits.
- NUM_THREADS, 4, hardware thread contexts (power of 2, >=1).
- TID_WIDTH, 2, thread-id width, equals clog2(NUM_THREADS), min 1.
- RESET_VECTOR, 0, word address loaded into thread 0 at reset.
- RAS_DEPTH, 4, return-stack entries per thread (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  global advance enable; 0 freezes all state except reset.
- stall  in  1  fetch back-pressure; 1 holds issue and PCs, but redirect/start/halt still apply.
- redirect_en  in  1  load a new PC into thread redirect_tid.
- redirect_tid  in  TID_WIDTH  target thread for redirect/start/halt/call/ret.
- redirect_addr  in  INST_ADDR_WIDTH  new word address.
- start_en  in  1  set thread redirect_tid RUNNING at redirect_addr.
- halt_en  in  1  set thread redirect_tid HALTED.
- pc_out  out  INST_ADDR_WIDTH+2  issued byte address; bits [1:0] always 0.
- pc_tid  out  TID_WIDTH  thread owning pc_out.
- pc_valid  out  1  pc_out/pc_tid valid this cycle.
- thread_running  out  NUM_THREADS  per-thread RUNNING status.

Behaviour:
- Reset:
  - pc_out=0, pc_tid=0, pc_valid=0.
  - Thread 0 is RUNNING with PC=RESET_VECTOR; all other threads are HALTED with PC=0.
  - Round-robin pointer = 0.
- Per-thread FSM:
  - HALTED -> RUNNING on start_en for that thread.
  - RUNNING -> HALTED on halt_en for that thread.
  - If halt_en and start_en target the same thread in the same cycle, halt wins.
- Issue (en=1, stall=0, at least one thread RUNNING):
  - Select the first RUNNING thread at or after the RR pointer, wrapping.
  - Next cycle: pc_out={PC[sel],2'b00}, pc_tid=sel, pc_valid=1.
  - PC[sel] <= PC[sel]+1, modulo 2^INST_ADDR_WIDTH (wraps from all-ones to 0).
  - RR pointer <= sel+1, modulo NUM_THREADS.
- Latency: one cycle from selection to registered outputs.
- No RUNNING thread, or stall=1, or en=0: pc_valid<=0 next cycle. pc_out and pc_tid hold their last values.
- Redirect (en=1):
  - PC[redirect_tid] <= redirect_addr. Takes priority over the increment for that thread.
  - If that thread is issued in the same cycle, the old PC is issued and the new PC takes effect for its next issue.
  - Redirecting a HALTED thread updates its PC; the thread stays HALTED.
- start_en also loads PC[redirect_tid] <= redirect_addr. A thread started this cycle is not eligible for issue until the next cycle.
- en=0: redirect, start, halt and call/ret are all ignored.
- Reset mid-operation overrides everything and discards all pending inputs.
- NUM_THREADS=1: the RR pointer is a constant 0 and behaviour reduces to a single counter with load.

Optional Feature:
- Macro: PC_SEQ_RAS_EN.
- Defined:
  - Adds ports call_en (in 1), ret_en (in 1), ras_underflow (out 1, reset 0).
  - Each thread gets a RAS_DEPTH-entry return stack.
  - call_en: pushes PC[redirect_tid]+1 and redirects to redirect_addr.
  - ret_en: pops into PC[redirect_tid].
  - Push onto a full stack overwrites the oldest entry (circular).
  - Pop from an empty stack loads PC=0 and pulses ras_underflow for 1 cycle.
  - Priority: redirect_en > call_en > ret_en.
- Undefined: none of these ports or stacks exist; the behaviour is as described above.

Decomposition:
- Shared package pc_seq_pkg:
  - Thread-state encoding: HALTED=1'b0, RUNNING=1'b1.
  - Byte-offset constant PC_BYTE_SHIFT=2.
  - Thread-id and word-address typedefs derived from the parameters.
- One sub-module: pc_rr_picker.
  - Combinational; takes the running mask and RR pointer, returns the selected tid and an any_running flag.
  - Reused later by the core scheduler.

Test Plan:
- Reset, then en=1 with thread 0 only running from RESET_VECTOR=0 -> pc_out 0x00, 0x04, 0x08 on consecutive cycles; pc_tid=0, pc_valid=1.
- start threads 1 and 2 at word 0x10 and 0x20 -> issue order tid 0,1,2,0,...; tid1 outputs 0x40, 0x44; tid2 outputs 0x80.
- Redirect the thread being issued (tid0 PC=5) to 0x3 in the same cycle -> pc_out=0x14 this issue; next tid0 issue pc_out=0x0C.
- Thread at PC=6'h3F issues -> pc_out=0xFC; next issue of that thread pc_out=0x00 (wrap).
- halt_en and start_en on tid1 in the same cycle; stall=1 for 3 cycles -> tid1 stays HALTED; pc_valid=0 during the stall; PCs unchanged afterwards.
- With PC_SEQ_RAS_EN: call at PC=2 to 0x30, then ret -> next issue pc_out=0x0C; a second ret -> PC=0 and ras_underflow pulses high for 1 cycle.
